// File: rtl/ram_uart_pkg.sv
// Shared types and constants for the RAM-to-UART hex dumper.
package ram_uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_SEND,
      S_DONE
   } state_t;

   localparam logic [7:0] ASCII_COLON     = 8'h3A;
   localparam logic [7:0] ASCII_CR        = 8'h0D;
   localparam logic [7:0] ASCII_LF        = 8'h0A;
   localparam int         CHARS_PER_ENTRY = 8;

   function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
      if (nib < 4'd10) return 8'h30 + {4'h0, nib};
      else             return 8'h37 + {4'h0, nib};
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serialiser; accepts a byte on valid && ready, start bit follows next cycle.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   logic          active_q, active_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [8:0]    shift_q, shift_d;
   logic          tx_q, tx_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '1;
         tx_q     <= 1'b1;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end

   // bit_q: 0 = start bit, 1..8 = data bits, 9 = stop bit (shifted in from the top)
   always_comb begin
      active_d = active_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      if (!active_q) begin
         if (valid) begin
            active_d = 1'b1;
            cnt_d    = '0;
            bit_d    = '0;
            shift_d  = {1'b1, data};
            tx_d     = 1'b0;
         end
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         if (bit_q == 4'd9) begin
            active_d = 1'b0;
            tx_d     = 1'b1;
         end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b1, shift_q[8:1]};
            bit_d   = bit_q + 4'd1;
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign ready = !active_q;
   assign tx    = tx_q;

endmodule

// File: rtl/ram_uart_dumper.sv
// Walks the display RAM once per start pulse and prints each entry as "A:DDDD\r\n" over UART.
module ram_uart_dumper
   import ram_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int DEPTH        = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [3:0]  ram_adr,
   input  logic [15:0] ram_dout,
   output logic        tx,
   output logic        busy,
   output logic [3:0]  cur_adr
);

   localparam logic [3:0] LAST_ADR = 4'(DEPTH - 1);
   localparam logic [2:0] LAST_CHR = 3'(CHARS_PER_ENTRY - 1);

   state_t      state_q, state_d;
   logic [3:0]  adr_q, adr_d;
   logic [3:0]  cur_q, cur_d;
   logic [15:0] hold_q, hold_d;
   logic [2:0]  chr_q, chr_d;

   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  tx_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         adr_q   <= '0;
         cur_q   <= '0;
         hold_q  <= '0;
         chr_q   <= '0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         cur_q   <= cur_d;
         hold_q  <= hold_d;
         chr_q   <= chr_d;
      end
   end

   always_comb begin
      tx_data = hex_to_ascii(adr_q);
      case (chr_q)
         3'd0:    tx_data = hex_to_ascii(adr_q);
         3'd1:    tx_data = ASCII_COLON;
         3'd2:    tx_data = hex_to_ascii(hold_q[15:12]);
         3'd3:    tx_data = hex_to_ascii(hold_q[11:8]);
         3'd4:    tx_data = hex_to_ascii(hold_q[7:4]);
         3'd5:    tx_data = hex_to_ascii(hold_q[3:0]);
         3'd6:    tx_data = ASCII_CR;
         default: tx_data = ASCII_LF;
      endcase
   end

   // The address character needs no RAM data, so LATCH already offers it;
   // this keeps the first start bit two cycles after FETCH.
   always_comb begin
      state_d  = state_q;
      adr_d    = adr_q;
      cur_d    = cur_q;
      hold_d   = hold_q;
      chr_d    = chr_q;
      tx_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               adr_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: state_d = S_LATCH;
         S_LATCH: begin
            hold_d   = ram_dout;
            tx_valid = 1'b1;
            state_d  = S_SEND;
            if (tx_ready) begin
               chr_d = chr_q + 3'd1;
               cur_d = adr_q;
            end
         end
         S_SEND: begin
            tx_valid = 1'b1;
            if (tx_ready) begin
               chr_d = chr_q + 3'd1;
               if (chr_q == 3'd0) cur_d = adr_q;
               // Prefetch the next entry while its predecessor's LF is on the wire.
               if (chr_q == LAST_CHR) begin
                  if (adr_q == LAST_ADR) begin
                     adr_d   = '0;
                     state_d = S_DONE;
                  end else begin
                     adr_d   = adr_q + 4'd1;
                     state_d = S_FETCH;
                  end
               end
            end
         end
         S_DONE: begin
            if (tx_ready) begin
               if (start) begin
                  adr_d   = '0;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk  (clk),
      .rst_n(rst_n),
      .data (tx_data),
      .valid(tx_valid),
      .ready(tx_ready),
      .tx   (tx)
   );

   // busy drops in the first idle cycle after the final stop bit.
   assign busy    = (state_q != S_IDLE) && !((state_q == S_DONE) && tx_ready);
   assign ram_adr = adr_q;
   assign cur_adr = cur_q;

endmodule

// File: tb/tb_ram_uart_dumper.sv
// Bench for ram_uart_dumper: decodes the UART stream and compares it with expected hex text.
module tb_ram_uart_dumper;

  localparam int CPB      = 4;
  localparam int DEPTH    = 16;
  localparam int FRAMES   = 8 * DEPTH;
  localparam int BUSY_END = FRAMES * 10 * CPB + (FRAMES - 1) + 2 + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ram_adr;
  logic [15:0] ram_dout;
  logic        tx;
  logic        busy;
  logic [3:0]  cur_adr;

  logic [15:0] mem [16];
  logic [15:0] expmem [16];
  logic [7:0]  exp_q [$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int frames_total = 0;

  // clock/reset block
  always #5 clk = ~clk;

  ram_uart_dumper #(
    .CLKS_PER_BIT(CPB),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .ram_adr(ram_adr),
    .ram_dout(ram_dout),
    .tx(tx),
    .busy(busy),
    .cur_adr(cur_adr)
  );

  always @(posedge clk) ram_dout <= mem[ram_adr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    string hx;
    hx = "0123456789ABCDEF";
    return hx[int'(n)];
  endfunction

  task automatic push_dump();
    for (int a = 0; a < DEPTH; a++) begin
      exp_q.push_back(hexc(4'(a)));
      exp_q.push_back(8'h3A);
      exp_q.push_back(hexc(expmem[a][15:12]));
      exp_q.push_back(hexc(expmem[a][11:8]));
      exp_q.push_back(hexc(expmem[a][7:4]));
      exp_q.push_back(hexc(expmem[a][3:0]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) mem[i] = 16'h1111 * 16'(i);
  endtask

  // scoreboard monitor: collects 40 samples per frame, checks shape, gap and byte
  int cyc = 0;
  bit in_frame = 1'b0;
  int fc = 0;
  int last_end = 0;
  int dump_frames = 0;
  logic samples [40];

  always @(negedge clk) begin : mon
    logic [7:0] b;
    logic [7:0] e;
    bit shape_ok;
    cyc++;
    if (!rst_n || !mon_en) begin
      in_frame = 1'b0;
    end else begin
      if (!busy && !in_frame) dump_frames = 0;
      if (in_frame) begin
        fc++;
        samples[fc] = tx;
        if (fc == 39) begin
          shape_ok = 1'b1;
          for (int i = 0; i < 10; i++)
            for (int j = 1; j < 4; j++)
              if (samples[4*i+j] !== samples[4*i]) shape_ok = 1'b0;
          if (samples[0] !== 1'b0 || samples[36] !== 1'b1) shape_ok = 1'b0;
          for (int j = 0; j < 8; j++) b[j] = samples[4*(j+1)];
          check("frame_shape", 32'(shape_ok), 32'd1);
          check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("byte", 32'(b), 32'(e));
          end
          in_frame = 1'b0;
          last_end = cyc;
          dump_frames++;
          frames_total++;
        end
      end else if (tx === 1'b0) begin
        in_frame = 1'b1;
        fc = 0;
        samples[0] = tx;
        if (dump_frames > 0) check("gap", 32'(cyc - last_end), 32'd2);
      end
    end
  end

  // driver task: mode 0 plain dump, 1 repeated start pulses, 2 RAM writes mid-dump
  task automatic run_dump(input int mode);
    int k;
    int f0;
    int bad;
    for (int a = 0; a < 16; a++) expmem[a] = mem[a];
    if (mode == 2) expmem[9] = 16'hBEEF;
    push_dump();
    f0 = frames_total;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 1;
    check("busy_n1", 32'(busy), 32'd1);
    check("adr_n1", 32'(ram_adr), 32'd0);
    check("tx_n1", 32'(tx), 32'd1);
    @(negedge clk) k = 2;
    check("tx_n2", 32'(tx), 32'd1);
    @(negedge clk) k = 3;
    check("tx_n3_start_bit", 32'(tx), 32'd0);
    while (busy === 1'b1 && k < 20000) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (k == 310) check("adr_prefetch_lf0", 32'(ram_adr), 32'd1);
      if (k == 330) check("cur_adr_entry0", 32'(cur_adr), 32'd0);
      if (k == 331) check("cur_adr_entry1", 32'(cur_adr), 32'd1);
      if (mode == 1 && (k % 700) == 50 && busy === 1'b1) start = 1'b1;
      if (mode == 2 && k == 1000) begin
        mem[9] = 16'hBEEF;
        mem[2] = 16'h1234;
      end
    end
    start = 1'b0;
    check("busy_fall_cycle", 32'(k), 32'(BUSY_END));
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("frame_count", 32'(frames_total - f0), 32'(FRAMES));
    check("adr_wrapped", 32'(ram_adr), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    if (mode == 1) begin
      bad = 0;
      repeat (200) begin
        @(negedge clk);
        if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("no_second_dump", 32'(bad), 32'd0);
    end
  endtask

  initial begin
    int bad;
    preload();
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_adr", 32'(ram_adr), 32'd0);
    check("rst_cur_adr", 32'(cur_adr), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_tx", 32'(tx), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    mon_en = 1'b1;

    run_dump(0);
    run_dump(1);
    run_dump(2);
    mem[9] = 16'h9999;
    mem[2] = 16'h2222;

    // asynchronous reset during the data bits of the third frame
    mon_en = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (99) @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_adr", 32'(ram_adr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("no_resume_after_reset", 32'(bad), 32'd0);
    check("cur_adr_after_reset", 32'(cur_adr), 32'd0);
    mon_en = 1'b1;
    @(negedge clk);
    run_dump(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
